// File: rtl/cur_fetch_pkg.sv
// cur_fetch_pkg: constants and pixel packing shared by the ME current-block path
package cur_fetch_pkg;
    localparam int BLK = 8;
    localparam int WORDS_PER_ROW = BLK / 4;
    localparam int WORDS_PER_BLK = BLK * WORDS_PER_ROW;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;
    // lowest-address pixel lands in bits [7:0]
    function automatic logic [31:0] pack_px(input logic [7:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction
endpackage

// File: rtl/cur_fetch_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign rdata = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/cur_fetch.sv
// cur_fetch: raster-order 8x8 current-block fetcher feeding the ME current-block buffer
module cur_fetch import cur_fetch_pkg::*; #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 48,
    parameter int ADDR_W = 16,
    parameter int BASE_ADDR = 0,
    parameter int FIFO_DEPTH = 4,
    localparam int NBX = FRAME_W / BLK,
    localparam int NBY = FRAME_H / BLK,
    localparam int BXW = NBX > 1 ? $clog2(NBX) : 1,
    localparam int BYW = NBY > 1 ? $clog2(NBY) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       cur_word,
    output logic              cur_valid,
    input  logic              need_cur,
    output logic              blk_first,
    output logic [BXW-1:0]    blk_x,
    output logic [BYW-1:0]    blk_y
);
    localparam int TW = 32 + BXW + BYW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FRAME_W - 4);
    // from the last block of a block row to the first block of the next one
    localparam logic [ADDR_W-1:0] ROWB_STEP = ADDR_W'(BLK + (BLK - 1) * FRAME_W);
    fetch_state_t state, state_n;
    logic h, rd_q, tag_first, row_end, blk_end, last_rd;
    logic [2:0] r;
    logic [BXW-1:0] bx, tag_x;
    logic [BYW-1:0] by, tag_y;
    logic [ADDR_W-1:0] addr, blk_base, next_base;
    logic [CW-1:0] count;
    logic [TW-1:0] head;
    assign mem_rd = state == RUN && 32'(count) + 32'(rd_q) < FIFO_DEPTH;
    assign mem_addr = addr;
    assign busy = state != IDLE;
    assign frame_done = state == DRAIN && count == '0 && !rd_q;
    assign cur_valid = count != '0;
    assign {blk_first, blk_y, blk_x, cur_word} = cur_valid ? head : '0;
    assign blk_end = h && r == 3'(BLK - 1);
    assign row_end = bx == BXW'(NBX - 1);
    assign last_rd = mem_rd && blk_end && row_end && by == BYW'(NBY - 1);
    assign next_base = blk_base + (row_end ? ROWB_STEP : ADDR_W'(BLK));
    always_comb begin
        state_n = state;
        if (state == IDLE && start) state_n = RUN;
        else if (state == RUN && last_rd) state_n = DRAIN;
        else if (frame_done) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            {h, r, bx, by} <= '0;
            addr <= '0;
            blk_base <= '0;
            rd_q <= 1'b0;
            {tag_first, tag_x, tag_y} <= '0;
        end else begin
            state <= state_n;
            rd_q <= mem_rd;
            if (mem_rd) {tag_first, tag_x, tag_y} <= {!h && r == 3'd0, bx, by};
            if (state == IDLE && start) begin
                {h, r, bx, by} <= '0;
                addr <= ADDR_W'(BASE_ADDR);
                blk_base <= ADDR_W'(BASE_ADDR);
            end else if (mem_rd) begin
                h <= !h;
                if (!h) addr <= addr + ADDR_W'(4);
                else if (!blk_end) begin
                    r <= r + 3'd1;
                    addr <= addr + ROW_STEP;
                end else begin
                    r <= 3'd0;
                    addr <= next_base;
                    blk_base <= next_base;
                    bx <= row_end ? '0 : bx + BXW'(1);
                    by <= row_end ? by + BYW'(1) : by;
                end
            end
        end
    sync_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(rd_q),
        .pop(need_cur && cur_valid),
        .wdata({tag_first, tag_y, tag_x, mem_rdata}),
        .rdata(head),
        .count(count)
    );
endmodule
